// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Operand forwarding and load-use hazard detection for the
//            in-order pipeline. Each decode-stage source register is compared
//            against the destinations of NSTG downstream result stages; the
//            youngest matching stage supplies the operand. A match on a load
//            that is not yet forwardable stalls IF/ID and injects a bubble
//            into EX.
// Ports    : clk, rst       - clock (rising edge), synchronous active-high reset
//            id_valid       - decode slot holds a valid instruction
//            id_src         - NSRC source indices, operand s at [s*AW +: AW]
//            id_src_used    - operand s is actually read
//            ex_hold        - downstream freeze, registered state holds
//            stg_wen        - stage k writes the register file
//            stg_rd         - stage k destination at [k*AW +: AW]
//            stg_load       - stage k carries a load
//            stall          - combinational freeze of PC and IF/ID
//            bubble         - registered, EX holds an injected NOP
//            fwd_sel        - registered per-operand select, 0 = regfile,
//                             k+1 = stage k
//            stall_cnt      - saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int NSTG     = 2,
  parameter int LOAD_STG = 1,
  parameter int SELW     = $clog2(NSTG + 1),
  parameter int CNTW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 ex_hold,
  input  logic [NSTG-1:0]      stg_wen,
  input  logic [NSTG*AW-1:0]   stg_rd,
  input  logic [NSTG-1:0]      stg_load,
  output logic                 stall,
  output logic                 bubble,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic [CNTW-1:0]      stall_cnt
);

  localparam logic [CNTW-1:0] C_CNT_MAX = {CNTW{1'b1}};

  logic [NSRC*NSTG-1:0] w_match;
  logic [NSRC*SELW-1:0] w_sel_nx;
  logic [NSRC-1:0]      w_haz;
  logic                 w_stall;

  logic [NSRC*SELW-1:0] r_fwd_sel;
  logic                 r_bubble;
  logic [CNTW-1:0]      r_stall_cnt;

  // Per operand/stage comparison. Register 0 is hard-wired and never forwarded.
  for (genvar gs = 0; gs < NSRC; gs++) begin : g_src
    for (genvar gk = 0; gk < NSTG; gk++) begin : g_stg
      assign w_match[gs*NSTG + gk] = id_src_used[gs]
                                   & stg_wen[gk]
                                   & (stg_rd[gk*AW +: AW] == id_src[gs*AW +: AW])
                                   & (id_src[gs*AW +: AW] != '0);
    end
  end

  // Walk stages oldest to youngest so the youngest match is written last and
  // wins. The hazard flag follows the winner only, so an older load that is
  // shadowed by a younger producer never stalls.
  always_comb begin
    w_sel_nx = '0;
    w_haz    = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (w_match[s*NSTG + k]) begin
          w_sel_nx[s*SELW +: SELW] = SELW'(k + 1);
          w_haz[s]                 = stg_load[k] & (k < LOAD_STG);
        end
      end
    end
  end

  // Stall ignores ex_hold on purpose: IF/ID must stay frozen while EX is held.
  assign w_stall = id_valid & (|w_haz) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_sel   <= '0;
      r_bubble    <= 1'b0;
      r_stall_cnt <= '0;
    end else if (!ex_hold) begin
      if (w_stall) begin
        r_fwd_sel <= '0;
        r_bubble  <= 1'b1;
        if (r_stall_cnt != C_CNT_MAX) begin
          r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end
      end else begin
        r_fwd_sel <= id_valid ? w_sel_nx : '0;
        r_bubble  <= 1'b0;
      end
    end
  end

  assign stall     = w_stall;
  assign bubble    = r_bubble;
  assign fwd_sel   = r_fwd_sel;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Self-checking bench for fwd_hazard_unit. Three instances share
//            the stimulus: default parameters, a 2-bit stall counter, and
//            LOAD_STG = NSTG.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int NSTG = 2;
  localparam int SELW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 id_valid;
  logic [NSRC*AW-1:0]   id_src;
  logic [NSRC-1:0]      id_src_used;
  logic                 ex_hold;
  logic [NSTG-1:0]      stg_wen;
  logic [NSTG*AW-1:0]   stg_rd;
  logic [NSTG-1:0]      stg_load;

  logic a_stall, a_bubble, b_stall, b_bubble, c_stall, c_bubble;
  logic [NSRC*SELW-1:0] a_sel, b_sel, c_sel;
  logic [15:0]          a_cnt, c_cnt;
  logic [1:0]           b_cnt;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .NSTG(NSTG), .LOAD_STG(1), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_hold(ex_hold), .stg_wen(stg_wen),
    .stg_rd(stg_rd), .stg_load(stg_load), .stall(a_stall), .bubble(a_bubble),
    .fwd_sel(a_sel), .stall_cnt(a_cnt));

  fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .NSTG(NSTG), .LOAD_STG(1), .CNTW(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_hold(ex_hold), .stg_wen(stg_wen),
    .stg_rd(stg_rd), .stg_load(stg_load), .stall(b_stall), .bubble(b_bubble),
    .fwd_sel(b_sel), .stall_cnt(b_cnt));

  fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .NSTG(NSTG), .LOAD_STG(2), .CNTW(16)) u_ld2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_hold(ex_hold), .stg_wen(stg_wen),
    .stg_rd(stg_rd), .stg_load(stg_load), .stall(c_stall), .bubble(c_bubble),
    .fwd_sel(c_sel), .stall_cnt(c_cnt));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic h,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic [1:0] wen, input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [1:0] ld);
    rst         = r;
    id_valid    = v;
    ex_hold     = h;
    id_src      = {s1, s0};
    id_src_used = used;
    stg_wen     = wen;
    stg_rd      = {rd1, rd0};
    stg_load    = ld;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r, v, h;
    logic [4:0] s0, s1;
    logic [1:0] used, wen;
    logic [4:0] rd0, rd1;
    logic [1:0] ld;
    logic       e_stall;
    logic [1:0] e_sel0, e_sel1;
    logic       e_bub;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic h, logic [4:0] s0, logic [4:0] s1,
                              logic [1:0] used, logic [1:0] wen, logic [4:0] rd0,
                              logic [4:0] rd1, logic [1:0] ld, logic es, logic [1:0] e0,
                              logic [1:0] e1, logic eb, logic [15:0] ec);
    vec_t t;
    t.r = r; t.v = v; t.h = h; t.s0 = s0; t.s1 = s1; t.used = used; t.wen = wen;
    t.rd0 = rd0; t.rd1 = rd1; t.ld = ld; t.e_stall = es; t.e_sel0 = e0; t.e_sel1 = e1;
    t.e_bub = eb; t.e_cnt = ec;
    return t;
  endfunction

  vec_t tbl[15];

  // ---------------- reference model ----------------
  int  LS  [3] = '{1, 1, 2};
  int  CMAX[3] = '{65535, 3, 65535};
  int  m_sel[3][2];
  bit  m_bub[3];
  int  m_cnt[3];

  // Youngest stage whose destination equals the source wins; it is a hazard
  // only if that producer is a load not yet past the forwardable stage.
  task automatic ref_op(input int s, input int ls, output int sel, output bit haz);
    int src;
    src = int'(id_src[s*AW +: AW]);
    sel = 0;
    haz = 1'b0;
    if (id_src_used[s] && src != 0) begin
      for (int k = 0; k < NSTG; k++) begin
        if (stg_wen[k] && int'(stg_rd[k*AW +: AW]) == src) begin
          sel = k + 1;
          haz = stg_load[k] && (k < ls);
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] get_stall(int i);
    return (i == 0) ? 32'(a_stall) : (i == 1) ? 32'(b_stall) : 32'(c_stall);
  endfunction
  function automatic logic [31:0] get_bub(int i);
    return (i == 0) ? 32'(a_bubble) : (i == 1) ? 32'(b_bubble) : 32'(c_bubble);
  endfunction
  function automatic logic [31:0] get_sel(int i, int s);
    logic [NSRC*SELW-1:0] v;
    v = (i == 0) ? a_sel : (i == 1) ? b_sel : c_sel;
    return 32'(v[s*SELW +: SELW]);
  endfunction
  function automatic logic [31:0] get_cnt(int i);
    return (i == 0) ? 32'(a_cnt) : (i == 1) ? 32'(b_cnt) : 32'(c_cnt);
  endfunction

  initial begin
    // Table: rows follow each other in time, counts are absolute.
    //           r  v  h  s0 s1 used  wen   rd0 rd1 ld     stall sel0 sel1 bub cnt
    tbl[0]  = mk(1, 1, 0, 7, 7, 2'b11, 2'b01, 7, 3, 2'b01, 0, 0, 0, 0, 0); // reset
    tbl[1]  = mk(1, 1, 0, 7, 7, 2'b11, 2'b01, 7, 3, 2'b01, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 5, 3, 2'b11, 2'b11, 5, 5, 2'b00, 0, 1, 0, 0, 0); // priority
    tbl[3]  = mk(0, 1, 0, 0, 0, 2'b11, 2'b01, 0, 4, 2'b00, 0, 0, 0, 0, 0); // r0
    tbl[4]  = mk(0, 1, 0, 2, 9, 2'b01, 2'b01, 9, 0, 2'b01, 0, 0, 0, 0, 0); // unused op
    tbl[5]  = mk(0, 1, 0, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01, 1, 0, 0, 1, 1); // load-use
    tbl[6]  = mk(0, 1, 0, 1, 7, 2'b11, 2'b10, 12, 7, 2'b10, 0, 0, 2, 0, 1); // load in stg1
    tbl[7]  = mk(0, 1, 1, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01, 1, 0, 2, 0, 1); // hold
    tbl[8]  = mk(0, 1, 1, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01, 1, 0, 2, 0, 1);
    tbl[9]  = mk(0, 1, 1, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01, 1, 0, 2, 0, 1);
    tbl[10] = mk(0, 1, 0, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01, 1, 0, 0, 1, 2); // release
    tbl[11] = mk(0, 1, 0, 7, 7, 2'b11, 2'b01, 7, 0, 2'b01, 1, 0, 0, 1, 3); // both ops
    tbl[12] = mk(0, 0, 0, 7, 7, 2'b11, 2'b01, 7, 0, 2'b01, 0, 0, 0, 0, 3); // invalid
    tbl[13] = mk(0, 1, 0, 6, 0, 2'b11, 2'b11, 6, 6, 2'b10, 0, 1, 0, 0, 3); // shadowed load
    tbl[14] = mk(1, 1, 0, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01, 0, 0, 0, 0, 0); // rst mid-stall

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].s0, tbl[i].s1, tbl[i].used,
            tbl[i].wen, tbl[i].rd0, tbl[i].rd1, tbl[i].ld);
      #1;
      chk($sformatf("tbl%0d.stall", i), 32'(a_stall), 32'(tbl[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.sel0", i), 32'(a_sel[1:0]), 32'(tbl[i].e_sel0));
      chk($sformatf("tbl%0d.sel1", i), 32'(a_sel[3:2]), 32'(tbl[i].e_sel1));
      chk($sformatf("tbl%0d.bubble", i), 32'(a_bubble), 32'(tbl[i].e_bub));
      chk($sformatf("tbl%0d.cnt", i), 32'(a_cnt), 32'(tbl[i].e_cnt));
    end

    // Saturation on the 2-bit counter, then reset during an active stall.
    drive(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01);
      #1;
      chk($sformatf("sat%0d.stall", i), 32'(b_stall), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.cnt", i), 32'(b_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("sat%0d.bubble", i), 32'(b_bubble), 32'd1);
    end
    drive(1, 1, 0, 1, 7, 2'b11, 2'b01, 7, 0, 2'b01);
    #1;
    chk("satrst.stall", 32'(b_stall), 32'd0);
    @(posedge clk); #1;
    chk("satrst.cnt", 32'(b_cnt), 32'd0);
    chk("satrst.bubble", 32'(b_bubble), 32'd0);
    chk("satrst.sel", 32'(b_sel), 32'd0);

    // LOAD_STG = NSTG: a load is never forwarded, dependant reads regfile.
    drive(0, 1, 0, 0, 7, 2'b10, 2'b01, 7, 0, 2'b01);
    #1;
    chk("ld2.stg0.stall", 32'(c_stall), 32'd1);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 7, 2'b10, 2'b10, 0, 7, 2'b10);
    #1;
    chk("ld2.stg1.stall", 32'(c_stall), 32'd1);
    chk("ld1.stg1.stall", 32'(a_stall), 32'd0);
    @(posedge clk); #1;
    chk("ld1.stg1.sel1", 32'(a_sel[3:2]), 32'd2);
    chk("ld2.stg1.cnt", 32'(c_cnt), 32'd2);
    drive(0, 1, 0, 0, 7, 2'b10, 2'b00, 0, 0, 2'b00);
    #1;
    chk("ld2.gone.stall", 32'(c_stall), 32'd0);
    @(posedge clk); #1;
    chk("ld2.gone.sel1", 32'(c_sel[3:2]), 32'd0);
    chk("ld2.gone.bubble", 32'(c_bubble), 32'd0);

    // Randomised phase against the reference model, all three instances.
    drive(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      m_sel[i][0] = 0; m_sel[i][1] = 0; m_bub[i] = 1'b0; m_cnt[i] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      int  nsel[3][2];
      bit  nst[3];
      drive(($urandom_range(29) == 0), ($urandom_range(5) != 0), ($urandom_range(4) == 0),
            5'($urandom_range(3)), 5'($urandom_range(3)), 2'($urandom_range(3)),
            2'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
            2'($urandom_range(3)));
      #1;
      for (int i = 0; i < 3; i++) begin
        bit h0, h1;
        ref_op(0, LS[i], nsel[i][0], h0);
        ref_op(1, LS[i], nsel[i][1], h1);
        nst[i] = id_valid && (h0 || h1) && !rst;
        chk($sformatf("rnd%0d.u%0d.stall", n, i), get_stall(i), 32'(nst[i]));
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          m_sel[i][0] = 0; m_sel[i][1] = 0; m_bub[i] = 1'b0; m_cnt[i] = 0;
        end else if (!ex_hold) begin
          if (nst[i]) begin
            m_sel[i][0] = 0; m_sel[i][1] = 0; m_bub[i] = 1'b1;
            m_cnt[i] = (m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : CMAX[i];
          end else begin
            m_sel[i][0] = id_valid ? nsel[i][0] : 0;
            m_sel[i][1] = id_valid ? nsel[i][1] : 0;
            m_bub[i]    = 1'b0;
          end
        end
        chk($sformatf("rnd%0d.u%0d.sel0", n, i), get_sel(i, 0), 32'(m_sel[i][0]));
        chk($sformatf("rnd%0d.u%0d.sel1", n, i), get_sel(i, 1), 32'(m_sel[i][1]));
        chk($sformatf("rnd%0d.u%0d.bubble", n, i), get_bub(i), 32'(m_bub[i]));
        chk($sformatf("rnd%0d.u%0d.cnt", n, i), get_cnt(i), 32'(m_cnt[i]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
